// File: rtl/pi5_hat_pkg.sv
// Shared definitions for the Pi5 HAT front-panel logic: debounce FSM state
// encodings, default timing constants and a counter-width helper.
package pi5_hat_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        PRESSED    = 3'd2,
        LONG       = 3'd3,
        DB_RELEASE = 3'd4
    } db_state_t;

    // Defaults assume a 50 MHz clk50m: 20 ms debounce window, 1 s long press.
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_LONG_CYCLES     = 50000000;
    localparam bit DEF_ACTIVE_LOW      = 1'b1;

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Pushbutton pin and debounced event outputs. The debouncer is the slave;
// whatever owns the pin and consumes the events is the master.
interface button_debounce_if;

    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic long_held;

    modport master (
        output btn_in,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  long_held
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output long_held
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to
// RESET_VALUE so the downstream logic sees a quiet input during reset.
module sync_2ff #(
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic clk50m,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RESET_VALUE;
            sync_reg <= RESET_VALUE;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/button_debounce.sv
// Pushbutton debouncer with press/release/long-press strobes. The raw pin is
// synchronized, normalised to "1 = pressed" and fed to a five-state FSM.
module button_debounce
    import pi5_hat_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
    input logic              clk50m,
    input logic              rst_n,
    button_debounce_if.slave btn
);

    localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int LONG_W = cnt_width(LONG_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_SAT    = '1;
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_SAT  = '1;

    logic btn_sync;
    logic pressed_s;

    db_state_t         state_reg, state_next;
    logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
    logic [LONG_W-1:0] long_cnt_reg, long_cnt_next;
    logic              long_seen_reg, long_seen_next;

    logic btn_level_reg, btn_level_next;
    logic press_pulse_reg, press_pulse_next;
    logic release_pulse_reg, release_pulse_next;
    logic long_pulse_reg, long_pulse_next;
    logic long_held_reg, long_held_next;

    // Synchronizer idles at the released pin level, which equals ACTIVE_LOW.
    sync_2ff #(
        .RESET_VALUE (ACTIVE_LOW)
    ) u_sync (
        .clk50m (clk50m),
        .rst_n  (rst_n),
        .d      (btn.btn_in),
        .q      (btn_sync)
    );

    assign pressed_s = btn_sync ^ ACTIVE_LOW;

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            db_cnt_reg        <= '0;
            long_cnt_reg      <= '0;
            long_seen_reg     <= 1'b0;
            btn_level_reg     <= 1'b0;
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
            long_pulse_reg    <= 1'b0;
            long_held_reg     <= 1'b0;
        end else begin
            state_reg         <= state_next;
            db_cnt_reg        <= db_cnt_next;
            long_cnt_reg      <= long_cnt_next;
            long_seen_reg     <= long_seen_next;
            btn_level_reg     <= btn_level_next;
            press_pulse_reg   <= press_pulse_next;
            release_pulse_reg <= release_pulse_next;
            long_pulse_reg    <= long_pulse_next;
            long_held_reg     <= long_held_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        db_cnt_next        = db_cnt_reg;
        long_cnt_next      = long_cnt_reg;
        long_seen_next     = long_seen_reg;
        btn_level_next     = btn_level_reg;
        press_pulse_next   = 1'b0;
        release_pulse_next = 1'b0;
        long_pulse_next    = 1'b0;
        long_held_next     = long_held_reg;

        case (state_reg)
            IDLE: begin
                if (pressed_s) begin
                    state_next  = DB_PRESS;
                    db_cnt_next = '0;
                end
            end

            DB_PRESS: begin
                if (!pressed_s) begin
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end else if (db_cnt_reg >= DB_LAST) begin
                    state_next       = PRESSED;
                    db_cnt_next      = '0;
                    long_cnt_next    = '0;
                    long_seen_next   = 1'b0;
                    press_pulse_next = 1'b1;
                    btn_level_next   = 1'b1;
                end else if (db_cnt_reg != DB_SAT) begin
                    db_cnt_next = db_cnt_reg + 1'b1;
                end
            end

            PRESSED: begin
                // Every cycle spent in PRESSED counts, including the one that
                // leaves for DB_RELEASE, so a glitch costs only its own length.
                if (long_cnt_reg != LONG_SAT) begin
                    long_cnt_next = long_cnt_reg + 1'b1;
                end
                if (!pressed_s) begin
                    state_next  = DB_RELEASE;
                    db_cnt_next = '0;
                end else if (long_cnt_reg >= LONG_LAST) begin
                    state_next      = LONG;
                    long_seen_next  = 1'b1;
                    long_pulse_next = 1'b1;
                    long_held_next  = 1'b1;
                end
            end

            LONG: begin
                if (!pressed_s) begin
                    state_next  = DB_RELEASE;
                    db_cnt_next = '0;
                end
            end

            DB_RELEASE: begin
                if (pressed_s) begin
                    state_next = long_seen_reg ? LONG : PRESSED;
                end else if (db_cnt_reg >= DB_LAST) begin
                    state_next         = IDLE;
                    db_cnt_next        = '0;
                    long_seen_next     = 1'b0;
                    release_pulse_next = 1'b1;
                    btn_level_next     = 1'b0;
                    long_held_next     = 1'b0;
                end else if (db_cnt_reg != DB_SAT) begin
                    db_cnt_next = db_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next  = IDLE;
                db_cnt_next = '0;
            end
        endcase
    end

    assign btn.btn_level     = btn_level_reg;
    assign btn.press_pulse   = press_pulse_reg;
    assign btn.release_pulse = release_pulse_reg;
    assign btn.long_pulse    = long_pulse_reg;
    assign btn.long_held     = long_held_reg;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=8, LONG_CYCLES=32,
// active-low button; expected edges are hand-computed from the pin change.
module tb_button_debounce;

    logic clk50m = 1'b0;
    logic rst_n  = 1'b0;

    button_debounce_if dbif ();

    button_debounce #(
        .DEBOUNCE_CYCLES (8),
        .LONG_CYCLES     (32),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk50m (clk50m),
        .rst_n  (rst_n),
        .btn    (dbif)
    );

    always #10 clk50m = ~clk50m;

    int edge_cnt = 0;
    always @(posedge clk50m) edge_cnt <= edge_cnt + 1;

    // Monotonic event counters; tests take baselines instead of clearing.
    int press_cnt    = 0;
    int release_cnt  = 0;
    int long_cnt     = 0;
    int press_edge   = -1;
    int release_edge = -1;
    int long_edge    = -1;
    int held_cycles  = 0;
    int level_cycles = 0;
    int overlap_cnt  = 0;

    always @(negedge clk50m) begin
        if (dbif.press_pulse) begin
            press_cnt++;
            press_edge = edge_cnt;
        end
        if (dbif.release_pulse) begin
            release_cnt++;
            release_edge = edge_cnt;
        end
        if (dbif.long_pulse) begin
            long_cnt++;
            long_edge = edge_cnt;
        end
        if (dbif.long_held) held_cycles++;
        if (dbif.btn_level) level_cycles++;
        if ((int'(dbif.press_pulse) + int'(dbif.release_pulse) + int'(dbif.long_pulse)) > 1)
            overlap_cnt++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    function automatic logic [4:0] outs();
        return {dbif.btn_level, dbif.press_pulse, dbif.release_pulse,
                dbif.long_pulse, dbif.long_held};
    endfunction

    int t0, t1, t2;
    int b_press, b_release, b_long, b_level, b_held;

    task automatic snap();
        b_press   = press_cnt;
        b_release = release_cnt;
        b_long    = long_cnt;
        b_level   = level_cycles;
        b_held    = held_cycles;
    endtask

    initial begin
        dbif.btn_in = 1'b1;
        rst_n       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk50m);
        check("reset_outputs", 32'(outs()), 0);
        @(negedge clk50m);
        rst_n = 1'b1;
        repeat (5) @(negedge clk50m);
        check("idle_outputs", 32'(outs()), 0);

        // Clean press held 20 cycles, then clean release
        snap();
        t0 = edge_cnt;
        dbif.btn_in = 1'b0;
        repeat (20) @(negedge clk50m);
        check("clean_press_count", press_cnt - b_press, 1);
        check("clean_press_edge", press_edge - t0, 11);
        check("clean_level", 32'(dbif.btn_level), 1);
        check("clean_no_long", long_cnt - b_long, 0);
        check("clean_no_release", release_cnt - b_release, 0);
        t1 = edge_cnt;
        dbif.btn_in = 1'b1;
        repeat (20) @(negedge clk50m);
        check("clean_release_edge", release_edge - t1, 11);
        check("clean_release_count", release_cnt - b_release, 1);
        check("clean_level_cycles", level_cycles - b_level, 20);
        check("clean_level_low", 32'(dbif.btn_level), 0);

        // Bounce: toggle every 3 cycles for 30 cycles, then held released
        snap();
        for (int i = 0; i < 10; i++) begin
            dbif.btn_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (3) @(negedge clk50m);
        end
        dbif.btn_in = 1'b1;
        repeat (20) @(negedge clk50m);
        check("bounce_no_press", press_cnt - b_press, 0);
        check("bounce_no_release", release_cnt - b_release, 0);
        check("bounce_level_cycles", level_cycles - b_level, 0);

        // Long press: held 60 cycles
        snap();
        t0 = edge_cnt;
        dbif.btn_in = 1'b0;
        repeat (60) @(negedge clk50m);
        t1 = edge_cnt;
        dbif.btn_in = 1'b1;
        repeat (20) @(negedge clk50m);
        check("long_press_edge", press_edge - t0, 11);
        check("long_pulse_count", long_cnt - b_long, 1);
        check("long_after_press", long_edge - press_edge, 32);
        check("long_release_edge", release_edge - t1, 11);
        check("long_held_cycles", held_cycles - b_held, 28);
        check("long_held_cleared", 32'(dbif.long_held), 0);

        // Release glitch of 4 cycles while PRESSED
        snap();
        t0 = edge_cnt;
        dbif.btn_in = 1'b0;
        repeat (16) @(negedge clk50m);
        dbif.btn_in = 1'b1;
        repeat (4) @(negedge clk50m);
        dbif.btn_in = 1'b0;
        repeat (44) @(negedge clk50m);
        check("glitch_press_edge", press_edge - t0, 11);
        check("glitch_no_release", release_cnt - b_release, 0);
        check("glitch_level", 32'(dbif.btn_level), 1);
        check("glitch_long_count", long_cnt - b_long, 1);
        check("glitch_long_not_early", 32'((long_edge - press_edge) >= 32), 1);
        check("glitch_long_not_late", 32'((long_edge - press_edge) <= 36), 1);
        t1 = edge_cnt;
        dbif.btn_in = 1'b1;
        repeat (20) @(negedge clk50m);
        check("glitch_release_edge", release_edge - t1, 11);

        // Reset abort 3 cycles before the press pulse would fire
        snap();
        t0 = edge_cnt;
        dbif.btn_in = 1'b0;
        repeat (8) @(negedge clk50m);
        rst_n = 1'b0;
        #1;
        check("abort_outputs_immediate", 32'(outs()), 0);
        repeat (5) @(negedge clk50m);
        check("abort_outputs_held", 32'(outs()), 0);
        check("abort_no_press", press_cnt - b_press, 0);
        t2 = edge_cnt;
        rst_n = 1'b1;
        repeat (15) @(negedge clk50m);
        check("abort_press_count", press_cnt - b_press, 1);
        check("abort_press_edge", press_edge - t2, 11);
        check("abort_level", 32'(dbif.btn_level), 1);
        dbif.btn_in = 1'b1;
        repeat (20) @(negedge clk50m);
        check("abort_release_count", release_cnt - b_release, 1);

        check("no_pulse_overlap", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable samples (20 ms at 50 MHz) before a level change is accepted; legal range >= 2.
REQ-002 Parameter LONG_CYCLES, default 50000000, is the accepted-press duration (1 s) before a long press is flagged; legal range > DEBOUNCE_CYCLES.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 means btn_in=0 is pressed; 0 means btn_in=1 is pressed.
REQ-004 clk50m  input  1  system clock, 50 MHz; the only clock.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 btn_in  input  1  raw, asynchronous, bouncing pushbutton pin.
REQ-007 btn_level  output  1  debounced pressed level, 1 = pressed.
REQ-008 press_pulse  output  1  one-cycle strobe on an accepted press.
REQ-009 release_pulse  output  1  one-cycle strobe on an accepted release.
REQ-010 long_pulse  output  1  one-cycle strobe when a press reaches LONG_CYCLES.
REQ-011 long_held  output  1  high from long_pulse until the accepted release.

Function
REQ-012 btn_in passes through a 2-flop synchronizer, then polarity normalisation ("pressed" = 1), before any other logic.
REQ-013 The FSM has five states: IDLE, DB_PRESS, PRESSED, LONG and DB_RELEASE.
REQ-014 IDLE transitions:
  - on a sampled pressed value -> DB_PRESS, debounce counter cleared to 0;
  - otherwise the FSM stays in IDLE.
REQ-015 DB_PRESS transitions:
  - on a released sample -> IDLE, no output change (glitch rejected);
  - on the DEBOUNCE_CYCLES-th consecutive pressed sample -> PRESSED.
REQ-016 The DB_PRESS -> PRESSED transition drives press_pulse=1 for one cycle, sets btn_level=1, and clears the long counter.
REQ-017 PRESSED transitions, with the long counter incrementing each cycle:
  - on a released sample -> DB_RELEASE;
  - on the LONG_CYCLES-th cycle in PRESSED -> LONG, with long_pulse=1 for one cycle and long_held=1.
REQ-018 LONG: on a released sample -> DB_RELEASE.
REQ-019 DB_RELEASE transitions:
  - on a pressed sample -> back to the originating state (PRESSED or LONG), tracked by a long_seen flag; the long counter holds and is neither cleared nor advanced;
  - on the DEBOUNCE_CYCLES-th consecutive released sample -> IDLE, with release_pulse=1 for one cycle, btn_level=0 and long_held=0.
REQ-020 All outputs shall be registered.
REQ-021 press_pulse shall rise exactly DEBOUNCE_CYCLES+3 rising edges after the first edge on which btn_in is stably pressed: 2 edges synchronizer, DEBOUNCE_CYCLES edges count, 1 edge output register.
REQ-022 Release latency shall be identical to press latency (REQ-021).
REQ-023 press_pulse, release_pulse and long_pulse shall never be high in the same cycle.
REQ-024 long_pulse shall fire at most once per accepted press.
REQ-025 Counter widths shall be $clog2 of the respective parameter plus 1; counters saturate and never wrap.
REQ-026 Each debounce counter restart (REQ-014, REQ-015, REQ-019) clears the counter to 0.

Reset
REQ-027 While rst_n=0, the following values shall hold:
  - synchronizer flops at the released pin level;
  - FSM in IDLE, all counters 0;
  - all outputs 0.
REQ-028 Reset assertion mid-press or mid-debounce aborts immediately with no pulse emitted.
REQ-029 Reset release with the button already held produces a normal press_pulse after the REQ-021 latency.

Structure
REQ-030 State encodings and a default-parameter constants block shall live in the shared package pi5_hat_pkg.
REQ-031 The synchronizer shall be a separate sub-module, sync_2ff (1 bit, async active-low reset, parameterised reset value).
REQ-032 The implementation shall be 120-400 lines of RTL.

Verification
All scenarios use DEBOUNCE_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1.
REQ-033 Clean press, btn_in 1->0 held 20 cycles -> press_pulse single-cycle at edge 11 after the change, btn_level=1, no long_pulse.
REQ-034 Bounce, btn_in toggling every 3 cycles for 30 cycles then held high -> no pulses, btn_level stays 0.
REQ-035 Long press, held low 60 cycles then released -> exactly one long_pulse 32 cycles after press_pulse, long_held=1 until release_pulse, which comes 11 cycles after the release.
REQ-036 Release glitch, during PRESSED btn_in high for 4 cycles then low -> no release_pulse, btn_level stays 1, long count resumes (long_pulse still at press_pulse+32+4 at most).
REQ-037 Reset abort, rst_n pulsed low at press_pulse-3 cycles -> all outputs 0 and no pulse during reset; press_pulse 11 cycles after rst_n release with btn_in still low.
